// File: rtl/controle_memoria_dados.sv
// rtl/controle_memoria_dados.sv - load/store sequencer for the byte-banked data memory
// One request at a time: range check, memory control sequencing, load extension, response hold.
module controle_memoria_dados #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]            mem_DataType,
  output logic                  mem_EscMen,
  output logic                  mem_ReadMen,
  input  logic [DATA_WIDTH-1:0] mem_saida
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ_ADDR = 3'd2,
    READ_DATA = 3'd3,
    RESP      = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0] L_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] L_TWO   = (ADDR_WIDTH+1)'(2);
  localparam logic [ADDR_WIDTH:0] L_FOUR  = (ADDR_WIDTH+1)'(4);
  localparam logic [ADDR_WIDTH:0] L_SPACE = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                  r_state;
  state_t                  w_state_next;
  logic [1:0]              r_size;
  logic                    r_signed;
  logic [DATA_WIDTH-1:0]   r_resp_rdata;
  logic                    r_resp_fault;
  logic [DATA_WIDTH-1:0]   r_mem_data;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [1:0]              r_mem_dtype;
  logic                    r_mem_escmen;
  logic                    r_mem_readmen;
  logic [ADDR_WIDTH:0]     w_nbytes;
  logic [ADDR_WIDTH:0]     w_end;
  logic                    w_fault;
  logic                    w_accept;
  logic [DATA_WIDTH-1:0]   w_ext;

  // Fault when the last byte would land past the top of the address space.
  always_comb begin
    w_nbytes = L_FOUR;
    case (req_size)
      2'b01:   w_nbytes = L_ONE;
      2'b10:   w_nbytes = L_TWO;
      default: w_nbytes = L_FOUR;
    endcase
    w_end   = {1'b0, req_addr} + w_nbytes;
    w_fault = (w_end > L_SPACE);
  end

  assign w_accept = (r_state == IDLE) && req_valid;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_fault)        w_state_next = RESP;
          else if (req_write) w_state_next = WRITE;
          else                w_state_next = READ_ADDR;
        end
      end
      WRITE:     w_state_next = RESP;
      READ_ADDR: w_state_next = READ_DATA;
      READ_DATA: w_state_next = RESP;
      RESP:      if (resp_ready) w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_ext = mem_saida;
    case (r_size)
      2'b01: if (r_signed) w_ext = {{(DATA_WIDTH-8){mem_saida[7]}}, mem_saida[7:0]};
      2'b10: if (r_signed) w_ext = {{(DATA_WIDTH-16){mem_saida[15]}}, mem_saida[15:0]};
      default: w_ext = mem_saida;
    endcase
  end

  // Memory strobes are derived from the state being entered so they are registered yet aligned with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_size        <= 2'b00;
      r_signed      <= 1'b0;
      r_resp_rdata  <= '0;
      r_resp_fault  <= 1'b0;
      r_mem_data    <= '0;
      r_mem_addr    <= '0;
      r_mem_dtype   <= 2'b00;
      r_mem_escmen  <= 1'b0;
      r_mem_readmen <= 1'b0;
    end else begin
      r_mem_escmen  <= (w_state_next == WRITE);
      r_mem_readmen <= (w_state_next == READ_ADDR) || (w_state_next == READ_DATA);
      if (w_accept) begin
        r_size       <= req_size;
        r_signed     <= req_signed;
        r_resp_rdata <= '0;
        r_resp_fault <= w_fault;
        if (!w_fault) begin
          r_mem_addr  <= req_addr;
          r_mem_dtype <= req_size;
          if (req_write) r_mem_data <= req_wdata;
        end
      end
      if (r_state == READ_DATA) r_resp_rdata <= w_ext;
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign resp_valid   = (r_state == RESP);
  assign resp_rdata   = r_resp_rdata;
  assign resp_fault   = r_resp_fault;
  assign mem_data     = r_mem_data;
  assign mem_addr     = r_mem_addr;
  assign mem_DataType = r_mem_dtype;
  assign mem_EscMen   = r_mem_escmen;
  assign mem_ReadMen  = r_mem_readmen;

endmodule
